// File: rtl/mdu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// MdU issue / interlock controller (module mdu_issue_ctrl)
//
// Sits between the EX pipeline register and the multiply/divide unit.  It
// fires a one-cycle start strobe for every MDU instruction that reaches EX,
// keeps its own countdown of how long a multiply or divide occupies the
// unit, and raises stall towards the hazard unit so that a following MDU
// instruction in ID waits until the unit is free.  No issue takes place
// while an exception/interrupt request is being taken.
//
// Parameters:
//   MUL_CYCLES  busy cycles after a mult/multu issue (1..255)
//   DIV_CYCLES  busy cycles after a div/divu issue   (1..255)
//
// Optional feature macro:
//   MDU_REQ_ABORT_EN  when defined, a request taken while the unit is busy
//                     cancels the operation on the next edge.  When not
//                     defined, a busy operation always runs to completion.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous reset, active low
//   E_valid    in   EX holds a real instruction (not a bubble)
//   E_MDUOp    in   MDU op of the EX instruction
//                   (0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi,
//                    6 mflo, 7 mthi, 8 mtlo, 9..15 none)
//   D_MDUOp    in   MDU op of the ID instruction, same encoding
//   pipe_hold  in   EX register frozen this cycle by an external stall
//   req        in   exception/interrupt request taken this cycle
//   start      out  issue strobe to the MDU
//   stall      out  freeze PC/IF/ID and bubble EX
//   busy       out  a multiply/divide is in flight
//   remain     out  busy cycles remaining, 0 when idle
// ---------------------------------------------------------------------------
module mdu_issue_ctrl #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       E_valid,
   input  logic [3:0] E_MDUOp,
   input  logic [3:0] D_MDUOp,
   input  logic       pipe_hold,
   input  logic       req,
   output logic       start,
   output logic       stall,
   output logic       busy,
   output logic [7:0] remain
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES);
   localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES);

   state_t     state;
   logic [7:0] cnt;
   logic       issued;

   logic       e_is_mdu;
   logic       e_is_muldiv;
   logic       e_is_mul;
   logic       e_is_div;
   logic       d_is_mdu;
   logic       abort;

   // Decode the EX and ID op fields.  Codes 9..15 behave like "no op", so
   // everything here is a plain range compare on the 4-bit encoding.
   always_comb begin
      e_is_mdu    = (E_MDUOp >= 4'd1) && (E_MDUOp <= 4'd8);
      e_is_mul    = (E_MDUOp == 4'd1) || (E_MDUOp == 4'd2);
      e_is_div    = (E_MDUOp == 4'd3) || (E_MDUOp == 4'd4);
      e_is_muldiv = e_is_mul || e_is_div;
      d_is_mdu    = (D_MDUOp >= 4'd1) && (D_MDUOp <= 4'd8);
   end

   // Issue only from IDLE, only once per EX instruction, and never in a
   // cycle where a request is being taken.  The reset term keeps the strobe
   // low while the block is held in reset, since it is not registered.
   always_comb begin
      start = reset && E_valid && e_is_mdu && !req && !issued
              && (state == IDLE);
   end

   // The ID instruction must wait if the unit is already occupied, or if
   // the EX instruction is starting a multi-cycle operation right now.
   // Non-MDU instructions in ID are never held back by this block.
   always_comb begin
      stall = d_is_mdu && ((state == BUSY) || (start && e_is_muldiv));
   end

   // Status outputs come straight from the registered state.
   always_comb begin
      busy   = (state == BUSY);
      remain = cnt;
   end

   // Whether a pending request cancels the current busy window depends on
   // whether the MDU in this build can restart after an exception.
`ifdef MDU_REQ_ABORT_EN
   always_comb begin
      abort = req;
   end
`else
   always_comb begin
      abort = 1'b0;
   end
`endif

   // Occupancy FSM.  IDLE always has cnt==0; BUSY holds 1..255 and counts
   // down, returning to IDLE on the edge where the last busy cycle ends.
   // mfhi/mflo/mthi/mtlo complete in one cycle and leave the FSM in IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start && e_is_mul) begin
                  state <= BUSY;
                  cnt   <= MUL_LOAD;
               end else if (start && e_is_div) begin
                  state <= BUSY;
                  cnt   <= DIV_LOAD;
               end
            end
            BUSY: begin
               if (abort || (cnt == 8'd1)) begin
                  state <= IDLE;
                  cnt   <= 8'd0;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 8'd0;
            end
         endcase
      end
   end

   // Remember that the instruction frozen in EX has already fired, so an
   // external stall cannot make it issue a second time.  Any edge where EX
   // is allowed to advance brings in a new instruction and clears the flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         issued <= 1'b0;
      end else if (!pipe_hold) begin
         issued <= 1'b0;
      end else if (start) begin
         issued <= 1'b1;
      end
   end

endmodule
